// File: rtl/jtframe_lfbuf_line_pkg.sv
// Shared types for the drawing-side line buffer of the line-based frame buffer.
package jtframe_lfbuf_line_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDraw = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } lfbuf_state_e;

  localparam logic [7:0] StallMax = 8'hff;

endpackage

// File: rtl/jtframe_lfbuf_dpram.sv
// Generic dual-port RAM: port A write-only, port B write plus asynchronous read.
module jtframe_lfbuf_dpram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          we_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [DW-1:0] din_a_i,
  input  logic          we_b_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [DW-1:0] din_b_i,
  output logic [DW-1:0] dout_b_o
);

  logic [DW-1:0] mem [2**AW];

  // Callers guarantee the two ports never write the same address in one cycle.
  always_ff @(posedge clk_i) begin
    if (we_a_i) mem[addr_a_i] <= din_a_i;
    if (we_b_i) mem[addr_b_i] <= din_b_i;
  end

  assign dout_b_o = mem[addr_b_i];

endmodule

// File: rtl/jtframe_lfbuf_line.sv
// Drawing-side line buffer: the core draws into one half while the frame
// buffer controller copies out and clears the other half.
module jtframe_lfbuf_line
  import jtframe_lfbuf_line_pkg::*;
#(
  parameter int unsigned VW     = 8,
  parameter int unsigned HW     = 9,
  parameter int unsigned VLINES = 240
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  output logic          frame,
  output logic          ln_hs,
  output logic [VW-1:0] ln_vnx,
  input  logic [HW-1:0] ln_addr,
  input  logic [15:0]   ln_data,
  input  logic          ln_we,
  input  logic          ln_end,
  output logic          ln_done,
  output logic [VW-1:0] ln_v,
  input  logic          line,
  input  logic [HW-1:0] fb_addr,
  input  logic          fb_clr,
  output logic [15:0]   fb_din,
  output logic [7:0]    stall
);

  localparam logic [VW-1:0] LastLine = VW'(VLINES - 1);

  lfbuf_state_e  state_q, state_d;
  logic          vs_q, line_q, fb_clr_q;
  logic          frame_q, frame_d;
  logic          ln_hs_q, ln_hs_d;
  logic [VW-1:0] ln_vnx_q, ln_vnx_d;
  logic          ln_done_q, ln_done_d;
  logic [VW-1:0] ln_v_q, ln_v_d;
  logic [7:0]    stall_q, stall_d;
  logic          drw_half_q, drw_half_d;
  logic          busy_q, busy_d;
  logic          tgl_seen_q, tgl_seen_d;
  logic          vs_rise, line_tgl, clr_fall, flip;

  assign vs_rise  = vs & ~vs_q;
  assign line_tgl = line ^ line_q;
  assign clr_fall = fb_clr_q & ~fb_clr;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    ln_hs_d    = 1'b0;
    ln_vnx_d   = ln_vnx_q;
    ln_done_d  = ln_done_q;
    ln_v_d     = ln_v_q;
    stall_d    = stall_q;
    drw_half_d = drw_half_q;
    busy_d     = busy_q;
    tgl_seen_d = tgl_seen_q;
    flip       = 1'b0;

    // The copy half is released only by a clear sweep ending after the toggle.
    if (clr_fall && (tgl_seen_q || line_tgl)) begin
      busy_d     = 1'b0;
      tgl_seen_d = 1'b0;
    end else if (busy_q && line_tgl) begin
      tgl_seen_d = 1'b1;
    end

    if (vs_rise) begin
      frame_d  = ~frame_q;
      ln_vnx_d = '0;
      ln_hs_d  = 1'b1;
      stall_d  = '0;
      state_d  = StDraw;
      if (state_q != StIdle) begin
        ln_done_d  = 1'b0;
        busy_d     = 1'b0;
        tgl_seen_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StDraw: begin
          if (ln_end) begin
            if (busy_q) state_d = StHold;
            else        flip    = 1'b1;
          end
        end
        StHold: begin
          if (busy_q) begin
            if (stall_q != StallMax) stall_d = stall_q + 8'd1;
          end else begin
            flip = 1'b1;
          end
        end
        StDone: begin
          if (line_tgl) begin
            ln_done_d = 1'b0;
            if (ln_vnx_q == LastLine) begin
              state_d = StIdle;
            end else begin
              ln_vnx_d = ln_vnx_q + 1'b1;
              ln_hs_d  = 1'b1;
              state_d  = StDraw;
            end
          end
        end
        default: ;
      endcase

      if (flip) begin
        drw_half_d = ~drw_half_q;
        ln_v_d     = ln_vnx_q;
        ln_done_d  = 1'b1;
        busy_d     = 1'b1;
        tgl_seen_d = 1'b0;
        state_d    = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vs_q       <= 1'b0;
      line_q     <= 1'b0;
      fb_clr_q   <= 1'b0;
      frame_q    <= 1'b0;
      ln_hs_q    <= 1'b0;
      ln_vnx_q   <= '0;
      ln_done_q  <= 1'b0;
      ln_v_q     <= '0;
      stall_q    <= '0;
      drw_half_q <= 1'b0;
      busy_q     <= 1'b0;
      tgl_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs;
      line_q     <= line;
      fb_clr_q   <= fb_clr;
      frame_q    <= frame_d;
      ln_hs_q    <= ln_hs_d;
      ln_vnx_q   <= ln_vnx_d;
      ln_done_q  <= ln_done_d;
      ln_v_q     <= ln_v_d;
      stall_q    <= stall_d;
      drw_half_q <= drw_half_d;
      busy_q     <= busy_d;
      tgl_seen_q <= tgl_seen_d;
    end
  end

  assign frame   = frame_q;
  assign ln_hs   = ln_hs_q;
  assign ln_vnx  = ln_vnx_q;
  assign ln_done = ln_done_q;
  assign ln_v    = ln_v_q;
  assign stall   = stall_q;

  jtframe_lfbuf_dpram #(
    .AW (HW + 1),
    .DW (16)
  ) u_ram (
    .clk_i    (clk),
    .we_a_i   (ln_we),
    .addr_a_i ({drw_half_q, ln_addr}),
    .din_a_i  (ln_data),
    .we_b_i   (fb_clr),
    .addr_b_i ({~drw_half_q, fb_addr}),
    .din_b_i  (16'h0000),
    .dout_b_o (fb_din)
  );

endmodule

// File: doc/jtframe_lfbuf_line.md
Name: jtframe_lfbuf_line

Overview:
- Drawing-side line buffer for the line-based frame buffer path. It is the producer that the frame buffer controller copies from.
- Holds a two-half line RAM. The game's object engine draws one line into one half while the controller copies out and clears the other half.
- Sequences the line numbers, issues draw requests to the core, and raises ln_done / ln_v toward the controller. It then waits for the controller's line toggle and fb_clr sweep before reusing a half.

Parameters:
- VW, 8, line-number width
- HW, 9, pixel-address width; each half holds 2**HW words
- VLINES, 240, lines drawn per frame (0..VLINES-1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vs  in  1  vertical sync; rising edge starts a frame
- frame  out  1  frame-buffer page select; toggles on every vs rising edge
- ln_hs  out  1  one-cycle pulse: core may start drawing line ln_vnx
- ln_vnx  out  VW  line the core must draw
- ln_addr  in  HW  core draw address
- ln_data  in  16  core draw data
- ln_we  in  1  core draw write strobe
- ln_end  in  1  one-cycle pulse: core finished drawing the current line
- ln_done  out  1  to controller: a drawn line is ready to copy
- ln_v  out  VW  to controller: line number of the ready line
- line  in  1  from controller; toggles when the copy completes
- fb_addr  in  HW  controller read/clear address
- fb_clr  in  1  controller clear strobe; clears one word per cycle
- fb_din  out  16  data at fb_addr in the copy half
- stall  out  8  saturating count of cycles spent in HOLD this frame

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - frame=0, ln_hs=0, ln_vnx=0, ln_done=0, ln_v=0, stall=0
  - drw_half=0, busy=0, state IDLE
  - RAM contents are not reset.
- Memory is 2*2**HW x16 with two ports:
  - Draw port: writes {drw_half, ln_addr} when ln_we is high, in any state.
  - Copy port: fb_din = mem[{~drw_half, fb_addr}] is a combinational (asynchronous) read, zero latency. The controller samples fb_din in the same cycle it presents fb_addr.
  - Clear: when fb_clr is high, writes 16'h0 to {~drw_half, fb_addr}.
  - The two ports always address different halves, so there is no collision.
- busy register:
  - Set when ln_done rises.
  - Cleared on the cycle fb_clr falls (registered fb_clr high, now low) after line has toggled.
- A line toggle is detected by comparing line against a registered copy of line.
- States:
  - IDLE: on vs rise -> frame<=~frame, ln_vnx<=0, pulse ln_hs, stall<=0, go DRAW.
  - DRAW: on ln_end -> if busy go HOLD, else flip drw_half, ln_v<=ln_vnx, ln_done<=1, go DONE.
  - HOLD: stall increments and saturates at 255. When busy clears, perform the DRAW flip actions and go DONE.
  - DONE: ln_done is held high until a line toggle is detected, then ln_done<=0. Next transition:
    - if ln_vnx==VLINES-1, go IDLE;
    - else ln_vnx<=ln_vnx+1, pulse ln_hs, go DRAW.
  - The core draws line N+1 while the controller clears the half used for line N.
- A vs rise in any non-IDLE state aborts the frame:
  - ln_done<=0, busy<=0, frame toggles, ln_vnx<=0, ln_hs pulses, go DRAW.
  - drw_half is kept.
- vs wins over a simultaneous ln_end or line toggle.
- ln_end outside DRAW is ignored.
- ln_vnx increments modulo 2**VW, but it never passes VLINES-1 because of the IDLE return.
- ln_hs is exactly one cycle wide, registered.

Decomposition:
- Shared package: state encoding (IDLE=0, DRAW=1, HOLD=2, DONE=3).
- One sub-module: jtframe_lfbuf_dpram. Generic dual-port RAM, AW/DW parameters, one write-only port, one write port with asynchronous read.

Test Plan:
1. Reset then vs rise -> frame=1, ln_hs pulse with ln_vnx=0; draw word 16'h1234 at ln_addr=5, pulse ln_end -> ln_done=1, ln_v=0, fb_din=16'h1234 when fb_addr=5.
2. Toggle line, sweep fb_clr over 512 cycles -> ln_done falls, ln_hs pulses with ln_vnx=1; after the next flip, address 5 of the reused half reads 16'h0000.
3. Pulse ln_end while the fb_clr sweep is still running -> state HOLD, stall counts the clear cycles remaining (e.g. 100); ln_done rises on the cycle after busy clears.
4. Run VLINES=240 lines -> last ln_v=239, block returns to IDLE, no further ln_hs until the next vs.
5. vs rise in the same cycle as ln_end during line 17 -> ln_done stays 0, ln_vnx=0, ln_hs pulses, frame toggles.
6. Assert rst_n low mid-DONE -> all outputs 0 immediately, without waiting for a clk edge.
